// File: rtl/sid_dca_scheduler_if.sv
// Voice DCA scheduler bus: control, per-voice operands in, per-voice amplitudes out.
interface sid_dca_scheduler_if #(
  parameter int NUM_VOICES = 3
);
  logic                       ce_1m;
  logic                       enable;
  logic [NUM_VOICES*12-1:0]   wave_in;
  logic [NUM_VOICES*8-1:0]    env_in;
  logic [NUM_VOICES-1:0]      voice_mute;
  logic [NUM_VOICES*12-1:0]   signal_out;
  logic                       busy;
  logic                       sweep_done;
  logic                       overrun;

  // Driver side: voice generators / sequencer.
  modport master (
    output ce_1m, enable, wave_in, env_in, voice_mute,
    input  signal_out, busy, sweep_done, overrun
  );

  // Scheduler side.
  modport slave (
    input  ce_1m, enable, wave_in, env_in, voice_mute,
    output signal_out, busy, sweep_done, overrun
  );
endinterface

// File: rtl/sid_dca_scheduler.sv
// Voice DCA scheduler: one shared 12x8 multiplier swept across all voices
// per ce_1m tick, 3 clocks per voice (LOAD, MUL, STORE).

// Per-voice amplitude holding register; written only on its own STORE.
module sid_dca_slot (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [11:0] d,
  output logic [11:0] q
);
  // Hold the amplitude until this voice is stored again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   q <= '0;
    else if (wr_en) q <= d;
  end
endmodule

module sid_dca_scheduler #(
  parameter int NUM_VOICES = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sid_dca_scheduler_if.slave   bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] { IDLE, LOAD, MUL, STORE } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] idx_q;
  logic [11:0]      wave_op_q;
  logic [7:0]       env_op_q;
  logic [19:0]      product_q;
  logic             sweep_done_q;
  logic             overrun_q;

  logic start, load_en, mul_en, store_en, last;

  // Lane views of the flat operand buses.
  logic [NUM_VOICES-1:0][11:0] wave_v;
  logic [NUM_VOICES-1:0][7:0]  env_v;
  logic [NUM_VOICES-1:0][11:0] slot_q;

  assign wave_v = bus.wave_in;
  assign env_v  = bus.env_in;
  assign last   = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and per-phase datapath strobes; enable only gates a new sweep.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    load_en  = 1'b0;
    mul_en   = 1'b0;
    store_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ce_1m && bus.enable) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end
      LOAD: begin
        load_en = 1'b1;
        state_d = MUL;
      end
      MUL: begin
        mul_en  = 1'b1;
        state_d = STORE;
      end
      STORE: begin
        store_en = 1'b1;
        state_d  = last ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Voice index: cleared at sweep start, advanced after each non-final STORE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               idx_q <= '0;
    else if (start)             idx_q <= '0;
    else if (store_en && !last) idx_q <= idx_q + IDX_W'(1);
  end

  // Operand capture happens in LOAD so late input changes still reach later voices.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wave_op_q <= '0;
      env_op_q  <= '0;
    end else if (load_en) begin
      wave_op_q <= bus.voice_mute[idx_q] ? 12'h000 : wave_v[idx_q];
      env_op_q  <= env_v[idx_q];
    end
  end

  // Full-width unsigned product; top 12 bits become the amplitude.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    product_q <= '0;
    else if (mul_en) product_q <= {8'h00, wave_op_q} * {12'h000, env_op_q};
  end

  // Completion pulse on the final STORE; overrun on any tick that lands outside IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sweep_done_q <= store_en && last;
      overrun_q    <= bus.ce_1m && (state_q != IDLE);
    end
  end

  genvar v;
  generate
    for (v = 0; v < NUM_VOICES; v++) begin : g_slot
      sid_dca_slot u_slot (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (store_en && (idx_q == IDX_W'(v))),
        .d       (product_q[19:8]),
        .q       (slot_q[v])
      );
    end
  endgenerate

  assign bus.signal_out = slot_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.sweep_done = sweep_done_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sid_dca_scheduler.sv
// Scoreboard bench for sid_dca_scheduler (3 voices): the driver pushes the
// expected completion cycle and slot values for each accepted tick, and the
// expected cycle of each overrun pulse; a monitor pops on every pulse.
module tb_sid_dca_scheduler;
  localparam int NV = 3;

  logic clock;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    int          done_cyc;
    logic [35:0] vals;
  } exp_t;

  exp_t sb[$];
  int   oq[$];

  sid_dca_scheduler_if #(.NUM_VOICES(NV)) bus ();

  sid_dca_scheduler #(.NUM_VOICES(NV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Hand-computed slot vectors {v2, v1, v0}; amplitude = (wave*env) >> 8.
  // fff*ff = fef01 -> fef ; 800*80 = 40000 -> 400 ; 001*ff = 000ff -> 000
  localparam logic [35:0] W_T2 = {12'h001, 12'h800, 12'hfff};
  localparam logic [23:0] E_T2 = {8'hff, 8'h80, 8'hff};
  localparam logic [35:0] X_T2 = {12'h000, 12'h400, 12'hfef};
  // 123*10 = 01230 -> 012 ; 456*20 = 08ac0 -> 08a ; 789*30 = 169b0 -> 169
  localparam logic [35:0] W_A  = {12'h789, 12'h456, 12'h123};
  localparam logic [23:0] E_A  = {8'h30, 8'h20, 8'h10};
  localparam logic [35:0] X_A  = {12'h169, 12'h08a, 12'h012};
  // Voice 1 muted with the basic inputs.
  localparam logic [35:0] X_M  = {12'h000, 12'h000, 12'hfef};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nedge(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Drive one ce_1m at the next negedge and record the expected sweep result.
  task automatic start_sweep(input logic [35:0] exp);
    exp_t e;
    @(negedge clock);
    bus.ce_1m = 1'b1;
    e.done_cyc = cyc + 1 + 3*NV;
    e.vals     = exp;
    sb.push_back(e);
    @(negedge clock);
    bus.ce_1m = 1'b0;
  endtask

  // Monitor: every sweep_done / overrun pulse must match the head of its queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus.sweep_done) begin
          if (sb.size() == 0) chk("unexpected_sweep_done", 1, 0);
          else begin
            e = sb.pop_front();
            chk("sweep_done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("signal_out", 64'(bus.signal_out), 64'(e.vals));
          end
        end else if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
          e = sb.pop_front();
          chk("missing_sweep_done", 0, 1);
        end
        if (bus.overrun) begin
          if (oq.size() == 0) chk("unexpected_overrun", 1, 0);
          else chk("overrun_cycle", 64'(cyc), 64'(oq.pop_front()));
        end else if (oq.size() != 0 && cyc > oq[0]) begin
          void'(oq.pop_front());
          chk("missing_overrun", 0, 1);
        end
      end
    end
  end

  initial begin
    cyc = 0; total = 0; bad = 0;
    reset_n        = 1'b0;
    bus.ce_1m      = 1'b0;
    bus.enable     = 1'b1;
    bus.wave_in    = '0;
    bus.env_in     = '0;
    bus.voice_mute = '0;

    // Reset state.
    nedge(2);
    chk("rst_signal_out", 64'(bus.signal_out), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_sweep_done", 64'(bus.sweep_done), 0);
    chk("rst_overrun", 64'(bus.overrun), 0);
    reset_n = 1'b1;
    nedge(2);

    // Basic sweep.
    bus.wave_in = W_T2; bus.env_in = E_T2;
    start_sweep(X_T2);
    nedge(2);
    chk("busy_mid_sweep", 64'(bus.busy), 1);
    nedge(10);
    chk("busy_after_sweep", 64'(bus.busy), 0);

    // Different operands, then voice 1 muted.
    bus.wave_in = W_A; bus.env_in = E_A;
    start_sweep(X_A);
    nedge(12);
    bus.wave_in = W_T2; bus.env_in = E_T2; bus.voice_mute = 3'b010;
    start_sweep(X_M);
    nedge(12);
    bus.voice_mute = 3'b000;

    // Overrun: tick 4 clocks in, tick on the final STORE, then a legal tick
    // exactly 3*NV+1 clocks after the first one.
    start_sweep(X_T2);                 // sampled at s; now at cyc s
    nedge(3);
    bus.ce_1m = 1'b1; oq.push_back(cyc + 1);   // sampled s+4
    nedge(1);
    bus.ce_1m = 1'b0;
    nedge(4);
    bus.ce_1m = 1'b1; oq.push_back(cyc + 1);   // sampled s+9, final STORE
    nedge(1);
    begin
      exp_t e;
      bus.ce_1m = 1'b1;                        // sampled s+10, IDLE again
      bus.wave_in = W_A; bus.env_in = E_A;
      e.done_cyc = cyc + 1 + 3*NV;
      e.vals     = X_A;
      sb.push_back(e);
    end
    nedge(1);
    bus.ce_1m = 1'b0;
    nedge(12);

    // enable=0: ticks ignored, outputs hold.
    bus.enable = 1'b0;
    bus.wave_in = W_T2; bus.env_in = E_T2;
    for (int k = 0; k < 3; k++) begin
      bus.ce_1m = 1'b1;
      nedge(1);
      bus.ce_1m = 1'b0;
      chk("disabled_busy", 64'(bus.busy), 0);
      nedge(4);
    end
    chk("disabled_hold", 64'(bus.signal_out), 64'(X_A));

    // Enable dropped mid-sweep: sweep still completes.
    bus.enable = 1'b1;
    start_sweep(X_T2);
    nedge(2);
    bus.enable = 1'b0;
    nedge(10);
    bus.enable = 1'b1;

    // Voice 2 wave changed during voice 0 MUL -> new value used (200*80 -> 100).
    bus.wave_in = {12'h100, 12'h800, 12'hfff}; bus.env_in = {8'h80, 8'h80, 8'hff};
    start_sweep({12'h100, 12'h400, 12'hfef});
    nedge(1);
    bus.wave_in[35:24] = 12'h200;
    nedge(11);
    // Voice 2 wave changed after its LOAD -> old value used (100*80 -> 080).
    bus.wave_in[35:24] = 12'h100;
    start_sweep({12'h080, 12'h400, 12'hfef});
    nedge(7);
    bus.wave_in[35:24] = 12'h300;
    nedge(5);

    // Reset mid-sweep clears asynchronously and discards the partial sweep.
    bus.wave_in = W_A; bus.env_in = E_A;
    start_sweep(X_A);
    nedge(5);
    sb.delete();
    reset_n = 1'b0;
    #1;
    chk("midrst_signal_out", 64'(bus.signal_out), 0);
    chk("midrst_busy", 64'(bus.busy), 0);
    nedge(2);
    reset_n = 1'b1;
    nedge(3);
    chk("postrst_busy", 64'(bus.busy), 0);
    chk("postrst_signal_out", 64'(bus.signal_out), 0);
    start_sweep(X_A);
    nedge(15);

    chk("sb_drained", 64'(sb.size()), 0);
    chk("overrun_q_drained", 64'(oq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
